id_fwd_scoreboard: RTL

- ID-stage operand forwarding and hazard unit for the pipelined MIPS-style core; generalised successor of the 2-port RAW forwarding logic.
- Resolves N read ports against the EX/MEM/WB and long-latency (mul/div) writeback paths.
- Tracks outstanding long-latency destinations in a registered scoreboard and raises a single pipeline stall.
- Keeps a saturating stall-cycle counter and a sticky stall watchdog.

---
 rtl/cpu_hazard_pkg.sv | 12 +
 rtl/id_fwd_port_mux.sv | 51 +++++
 rtl/id_fwd_scoreboard.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_hazard_pkg.sv
// cpu_hazard_pkg: shared widths, register-count helper and forwarding source enum for the ID hazard logic
package cpu_hazard_pkg;
  localparam int DEF_NUM_RD_PORTS = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_TIMEOUT_CYC = 64;
  function automatic int nreg(input int addr_w);
    return 1 << addr_w;
  endfunction
  typedef enum logic [2:0] {SRC_RF, SRC_LONG, SRC_WB, SRC_MEM, SRC_EX} fwd_src_e;
endpackage

// File: rtl/id_fwd_port_mux.sv
// id_fwd_port_mux: per-read-port operand forwarding and stall request; ID_EX_FWD_EN enables EX-stage forwarding
module id_fwd_port_mux
  import cpu_hazard_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              used,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              long_done,
  input  logic [ADDR_W-1:0] long_waddr,
  input  logic [DATA_W-1:0] long_wdata,
  input  logic              pend,
  output logic [DATA_W-1:0] data,
  output logic              stall_req,
  output fwd_src_e          src
);
  logic nz, ex_hit, mem_hit, wb_hit, long_hit, ex_fwd, ex_stall;
  assign nz       = addr != '0;
  assign ex_hit   = nz & ex_we & (ex_waddr == addr);
  assign mem_hit  = nz & mem_we & (mem_waddr == addr);
  assign wb_hit   = nz & wb_we & (wb_waddr == addr);
  assign long_hit = nz & long_done & (long_waddr == addr);
`ifdef ID_EX_FWD_EN
  assign ex_fwd   = ex_hit & !ex_is_load;
  assign ex_stall = ex_hit & ex_is_load;
`else
  logic unused_ex;
  assign unused_ex = ^{ex_wdata, ex_is_load};
  assign ex_fwd    = 1'b0;
  assign ex_stall  = ex_hit;
`endif
  always_comb begin
    src = ex_fwd ? SRC_EX : mem_hit ? SRC_MEM : wb_hit ? SRC_WB : long_hit ? SRC_LONG : SRC_RF;
    data = src == SRC_EX ? ex_wdata : src == SRC_MEM ? mem_wdata : src == SRC_WB ? wb_wdata :
           src == SRC_LONG ? long_wdata : rf_data;
    // a same-cycle long writeback releases the pending stall and is forwarded instead
    stall_req = used & (ex_stall | (nz & pend & !long_hit));
  end
endmodule

// File: rtl/id_fwd_scoreboard.sv
// id_fwd_scoreboard: ID-stage forwarding, long-latency scoreboard, stall counter and watchdog; ID_EX_FWD_EN enables EX forwarding
module id_fwd_scoreboard
  import cpu_hazard_pkg::*;
#(
  parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD_PORTS-1:0]        rd_used_i,
  input  logic [NUM_RD_PORTS*DATA_W-1:0] rf_data_i,
  output logic [NUM_RD_PORTS*DATA_W-1:0] rdata_o,
  input  logic                           ex_we_i,
  input  logic [ADDR_W-1:0]              ex_waddr_i,
  input  logic [DATA_W-1:0]              ex_wdata_i,
  input  logic                           ex_is_load_i,
  input  logic                           mem_we_i,
  input  logic [ADDR_W-1:0]              mem_waddr_i,
  input  logic [DATA_W-1:0]              mem_wdata_i,
  input  logic                           wb_we_i,
  input  logic [ADDR_W-1:0]              wb_waddr_i,
  input  logic [DATA_W-1:0]              wb_wdata_i,
  input  logic                           id_valid_i,
  input  logic                           id_we_i,
  input  logic [ADDR_W-1:0]              id_waddr_i,
  input  logic                           id_long_i,
  input  logic                           flush_i,
  input  logic                           long_done_i,
  input  logic [ADDR_W-1:0]              long_waddr_i,
  input  logic [DATA_W-1:0]              long_wdata_i,
  output logic                           stall_o,
  output logic [nreg(ADDR_W)-1:0]        pending_o,
  output logic [CNT_W-1:0]               stall_cnt_o,
  output logic                           timeout_o
);
  localparam int NREG = nreg(ADDR_W);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [NREG-1:0] pending, pending_d, set_vec, clr_vec;
  logic [NUM_RD_PORTS-1:0] port_stall;
  logic [NUM_RD_PORTS*DATA_W-1:0] port_data;
  fwd_src_e src_unused [NUM_RD_PORTS];
  logic [TW-1:0] consec, consec_d;
  logic waw_hit, fire;
  genvar p;
  for (p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    id_fwd_port_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux (
      .addr(rd_addr_i[p*ADDR_W +: ADDR_W]), .used(rd_used_i[p]), .rf_data(rf_data_i[p*DATA_W +: DATA_W]),
      .ex_we(ex_we_i), .ex_waddr(ex_waddr_i), .ex_wdata(ex_wdata_i), .ex_is_load(ex_is_load_i),
      .mem_we(mem_we_i), .mem_waddr(mem_waddr_i), .mem_wdata(mem_wdata_i),
      .wb_we(wb_we_i), .wb_waddr(wb_waddr_i), .wb_wdata(wb_wdata_i),
      .long_done(long_done_i), .long_waddr(long_waddr_i), .long_wdata(long_wdata_i),
      .pend(pending[rd_addr_i[p*ADDR_W +: ADDR_W]]),
      .data(port_data[p*DATA_W +: DATA_W]), .stall_req(port_stall[p]), .src(src_unused[p])
    );
  end
  always_comb begin
    waw_hit = id_valid_i & id_we_i & pending[id_waddr_i] & !(long_done_i & (long_waddr_i == id_waddr_i));
    stall_o = rst_n_i & ((|port_stall) | waw_hit);
    rdata_o = rst_n_i ? port_data : '0;
    fire = id_valid_i & !stall_o & !flush_i;
    set_vec = (fire & id_long_i & id_we_i) ? NREG'(1) << id_waddr_i : '0;
    clr_vec = long_done_i ? NREG'(1) << long_waddr_i : '0;
    // set wins over a same-cycle clear; register 0 is never tracked
    pending_d = (set_vec | (pending & ~clr_vec)) & ~NREG'(1);
    consec_d = !stall_o ? '0 : consec == TW'(TIMEOUT_CYC) ? consec : consec + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      pending <= '0;
      stall_cnt_o <= '0;
      consec <= '0;
      timeout_o <= 1'b0;
    end else begin
      pending <= pending_d;
      if (stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      consec <= consec_d;
      timeout_o <= timeout_o | (consec_d == TW'(TIMEOUT_CYC));
    end
  assign pending_o = pending;
endmodule
